// File: rtl/fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_stage
// Purpose  : Read-side adapter for a show-ahead FIFO. A 2-entry skid buffer
//            turns FIFO output into a registered valid/ready stream.
//            Optional flush port enabled by defining FIFO_POP_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
module fifo_pop_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_read,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_occupancy
`ifdef FIFO_POP_FLUSH_EN
    ,
    input  logic                  i_flush
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [DATA_WIDTH-1:0] w_tail_next;
    logic                  w_flush;
    logic                  w_push;
    logic                  w_pop;

`ifdef FIFO_POP_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Read strobe is a function of flops and FIFO flags only, never i_ready.
    assign o_fifo_read = !i_fifo_empty && (r_state != ST_TWO) && i_rstn && !w_flush;
    assign o_valid     = (r_state != ST_EMPTY);
    assign o_data      = r_head;
    assign w_push      = o_fifo_read;
    assign w_pop       = o_valid && i_ready;

    always_comb begin
        o_occupancy = 2'd0;
        case (r_state)
            ST_ONE:  o_occupancy = 2'd1;
            ST_TWO:  o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_head_next  = i_fifo_data;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_next = i_fifo_data;
                end else if (w_push) begin
                    w_tail_next  = i_fifo_data;
                    w_state_next = ST_TWO;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_head_next  = r_tail;
                    w_state_next = ST_ONE;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // Flush discards whatever the buffer holds, overriding push and pop.
        if (w_flush) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pop_stage
// Purpose  : Scoreboard bench for fifo_pop_stage with a queue-based FIFO model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_pop_stage;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] fdata = 8'h00;
    logic       fempty = 1'b1;
    logic       rd;
    logic       vld;
    logic [7:0] odata;
    logic       rdy = 1'b0;
    logic [1:0] occ;
    logic       fl;
`ifdef FIFO_POP_FLUSH_EN
    logic       flush = 1'b0;
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    always #5 clk = ~clk;

    fifo_pop_stage #(.DATA_WIDTH(8)) u_dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_fifo_data  (fdata),
        .i_fifo_empty (fempty),
        .o_fifo_read  (rd),
        .o_valid      (vld),
        .o_data       (odata),
        .i_ready      (rdy),
        .o_occupancy  (occ)
`ifdef FIFO_POP_FLUSH_EN
        ,
        .i_flush      (flush)
`endif
    );

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         rd_s = 1'b0;
    int         rd_cnt = 0;
    int         acc_cnt = 0;
    int         max_occ = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: everything here is sampled on the falling edge.
    always @(negedge clk) begin
        int exp_occ;
        if (!rstn) begin
            chk("reset_valid", vld, 0);
            chk("reset_occ", occ, 0);
            chk("reset_data", odata, 0);
            chk("reset_read", rd, 0);
            rd_s       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_occ = exp_q.size() - fifo_q.size();
            chk("occupancy", occ, exp_occ);
            chk("valid", vld, exp_occ != 0);
            chk("read_strobe", rd, !fempty && exp_occ < 2 && !fl);
            if (prev_stall) chk("stall_hold", odata, prev_data);
            if (vld && rdy) begin
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else chk("data", odata, exp_q.pop_front());
                acc_cnt++;
            end
            rd_s = rd;
            if (rd) rd_cnt++;
            if (int'(occ) > max_occ) max_occ = int'(occ);
            prev_stall = vld && !rdy;
            prev_data  = odata;
            if (fl) begin
                while (exp_q.size() > fifo_q.size()) void'(exp_q.pop_front());
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drive();
        fempty = (fifo_q.size() == 0);
        fdata  = fempty ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        drive();
    endtask

    task automatic load(logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        drive();
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int sent;
        int guard;
        // Reset and idle
        repeat (3) cycle();
        rstn = 1'b1;
        repeat (10) cycle();
        chk("idle_reads", rd_cnt, 0);

        // Streaming 0x01..0x08
        rdy = 1'b1;
        rd_cnt = 0; acc_cnt = 0;
        for (int i = 1; i <= 8; i++) load(8'(i));
        repeat (9) cycle();
        chk("stream_accepts_9cyc", acc_cnt, 8);
        repeat (3) cycle();
        chk("stream_reads", rd_cnt, 8);
        chk("stream_accepts", acc_cnt, 8);

        // Backpressure 0x10..0x15
        rdy = 1'b0;
        rd_cnt = 0; max_occ = 0;
        for (int i = 'h10; i <= 'h15; i++) load(8'(i));
        repeat (5) cycle();
        chk("bp_max_occ", max_occ, 2);
        chk("bp_reads", rd_cnt, 2);
        chk("bp_head", odata, 8'h10);
        rdy = 1'b1;
        drain("bp", 20);

        // Random ready and random FIFO fill
        sent = 0; guard = 0;
        while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
            cycle();
            rdy = ($urandom_range(1, 0) == 1);
            if (sent < 1000 && fifo_q.size() < 8 && $urandom_range(2, 0) != 0) begin
                load(8'($urandom));
                sent++;
            end
            guard++;
        end
        chk("random_drained", exp_q.size(), 0);

        // Reset while holding two entries
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) load(8'(8'h40 + i));
        repeat (3) cycle();
        chk("pre_reset_occ", occ, 2);
        rstn = 1'b0;
        #1;
        chk("async_reset_valid", vld, 0);
        chk("async_reset_occ", occ, 0);
        fifo_q.delete();
        exp_q.delete();
        drive();
        repeat (2) cycle();
        rstn = 1'b1;
        for (int i = 'h30; i <= 'h33; i++) load(8'(i));
        rdy = 1'b1;
        drain("post_reset", 20);

`ifdef FIFO_POP_FLUSH_EN
        // Flush while holding 0x20/0x21 with the FIFO still non-empty
        rdy = 1'b0;
        for (int i = 'h20; i <= 'h23; i++) load(8'(i));
        repeat (3) cycle();
        chk("pre_flush_occ", occ, 2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_valid", vld, 0);
        chk("flush_occ", occ, 0);
        rdy = 1'b1;
        cycle();
        cycle();
        chk("flush_next_word", odata, 8'h22);
        drain("flush", 20);
`endif

        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_pop_stage.md
# fifo_pop_stage

Read-side adapter for the synchronous show-ahead FIFO. It drives the FIFO's read strobe and turns the FIFO output into a registered valid/ready stream for downstream pipeline stages, such as the decode front-end.

- A 2-entry skid buffer sustains one transfer per cycle.
- No combinational path exists from `i_ready` to `o_fifo_read`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload width; must match the FIFO's `DATA_WIDTH`.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_fifo_data`  in  DATA_WIDTH  FIFO read data, valid at the current read pointer.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_read`  out  1  FIFO read strobe; the FIFO pops on the rising edge where this is high.
- `o_valid`  out  1  downstream payload valid.
- `o_data`  out  DATA_WIDTH  downstream payload; registered.
- `i_ready`  in  1  downstream accept.
- `o_occupancy`  out  2  entries held: 0, 1 or 2.
- `i_flush`  in  1  discard buffered entries; present only with `FIFO_POP_FLUSH_EN`.

## Operation
Internal storage:
- `head` register: drives `o_data`.
- `tail` register.
- State register: EMPTY / ONE / TWO.

Events:
- push = `o_fifo_read`, which is `!i_fifo_empty && state != TWO && i_rstn`.
- pop = `o_valid && i_ready`.

Derived outputs:
- `o_valid` = (state != EMPTY).
- `o_occupancy` = 0 / 1 / 2 for EMPTY / ONE / TWO.

Transitions (evaluated each rising edge):
- EMPTY:
  - push: `head <= i_fifo_data`, go to ONE.
  - Otherwise: stay in EMPTY.
  - pop cannot occur in EMPTY.
- ONE:
  - push and pop: `head <= i_fifo_data`, stay in ONE.
  - push, no pop: `tail <= i_fifo_data`, go to TWO.
  - pop, no push: go to EMPTY; `head` keeps its stale value.
  - Neither: hold.
- TWO:
  - pop: `head <= tail`, go to ONE.
  - No pop: hold.
  - push is impossible in TWO.

Ordering and stability rules:
- Entries leave in FIFO order; no entry is dropped or duplicated.
- While `o_valid && !i_ready`, `o_data` must not change.
- `o_fifo_read` is never high while `i_fifo_empty` is high.
- `tail` and `head` are not cleared when consumed; only the state register defines validity.

## Timing
- Reset (asynchronous assert, synchronous deassert at the next edge):
  - State goes to EMPTY, so `o_valid` = 0 and `o_occupancy` = 0.
  - `head` = 0, so `o_data` = 0.
  - `o_fifo_read` = 0 while `i_rstn` is low.
- Latency: FIFO non-empty at edge-cycle N with the stage EMPTY gives `o_valid` = 1 and the word on `o_data` in cycle N+1.
- Throughput: 1 word/cycle with `i_ready` held high and FIFO non-empty; the stage settles in ONE.
- Backpressure:
  - `i_ready` low for k cycles absorbs at most 1 extra word (TWO), then `o_fifo_read` drops.
  - The first cycle after `i_ready` returns high, the stage pops from TWO; it does not push in that cycle.
- `o_fifo_read` depends only on the state register, `i_fifo_empty` and `i_rstn`. Its timing path therefore starts at a flop or at the FIFO count.
- Reset asserted mid-stream: buffered entries are lost. The FIFO, sharing the reset, is cleared too.

## Configuration
`FIFO_POP_FLUSH_EN`:
- Defined:
  - The `i_flush` port exists.
  - While `i_flush` is high, `o_fifo_read` is forced to 0.
  - At the edge, state goes to EMPTY regardless of pop/push; flush has priority over both.
  - `o_valid` is 0 the cycle after the flush.
  - A pop handshake in the flush cycle still counts as a completed transfer downstream.
  - The FIFO itself is not flushed.
- Not defined:
  - No `i_flush` port.
  - Behaviour is identical to the defined case with `i_flush` tied to 0.

## Test plan
- Reset and idle: hold `i_rstn` low, then release with `i_fifo_empty` = 1.
  - During and after reset: `o_valid` = 0, `o_occupancy` = 0, `o_data` = 0.
  - `o_fifo_read` stays 0 for 10 cycles.
- Streaming: FIFO holds 0x01..0x08, `i_ready` = 1.
  - First `o_valid` appears 1 cycle after the first `o_fifo_read`.
  - 0x01..0x08 are accepted on 8 consecutive cycles.
  - `o_fifo_read` is high for exactly 8 cycles.
- Backpressure: FIFO holds 0x10..0x15; `i_ready` = 0 for 5 cycles, then 1.
  - `o_occupancy` reaches 2.
  - `o_fifo_read` is high for exactly 2 cycles during the stall.
  - `o_data` is 0x10 and stable throughout the stall.
  - Output order is 0x10..0x15 with no gaps or duplicates.
- Random `i_ready` (50%) with random FIFO fill over 1000 words:
  - Scoreboard shows in-order, lossless delivery.
  - `o_fifo_read` && `i_fifo_empty` is never 1.
- Reset mid-stream: assert `i_rstn` low while in TWO.
  - `o_valid` drops immediately (asynchronously).
  - Restart after reset delivers fresh FIFO data only.
- Flush (`FIFO_POP_FLUSH_EN` defined), in TWO holding 0x20/0x21 with FIFO non-empty:
  - Pulse `i_flush` for 1 cycle.
  - Next cycle: `o_valid` = 0 and `o_occupancy` = 0.
  - `o_fifo_read` = 0 during the flush cycle.
  - Next delivered word is the FIFO head, not 0x21.
